// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode and branch/memory status in, pipeline-advance controls out.
interface pipe_hazard_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  id_ir;
    logic             id_valid;
    logic             ex_branch_taken;
    logic             mem_ready;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_freeze;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_ir, id_valid, ex_branch_taken, mem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze, fwd_a, fwd_b, stall_cnt
    );
    modport slave (
        input  id_ir, id_valid, ex_branch_taken, mem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW hazard detection, stall/flush/freeze sequencing and EX operand forwarding.
// PIPE_FWD_EN enables forwarding; without it decode stalls until every producer has left WB.
module pipe_hazard_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [1:0] RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } slot_t;

    slot_t            dec, ex, mem, wb;
    logic [XLEN-1:0]  ir;
    logic [6:0]       op;
    logic             use1, use2, dep_ex, lu, frz, br, stall;
    logic [1:0]       st, nxt;
    logic [CNT_W-1:0] cnt;
    logic             unused_ok;

    assign ir   = hz.id_ir;
    assign op   = ir[6:0];
    assign use1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    assign use2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    assign dec  = '{v: hz.id_valid, rd: ir[11:7],
                    wr: (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                                    7'b1100111, 7'b0110111, 7'b0010111}) && ir[11:7] != 5'd0,
                    ld: op == 7'b0000011, rs1: ir[19:15], rs2: ir[24:20]};

    assign dep_ex = ex.v && ex.wr && ((use1 && ex.rd == dec.rs1) || (use2 && ex.rd == dec.rs2));

`ifdef PIPE_FWD_EN
    localparam bit LU_HOLD = 1'b0;
    assign lu       = hz.id_valid && ex.ld && dep_ex;
    assign hz.fwd_a = (mem.v && mem.wr && mem.rd == ex.rs1) ? 2'b01 :
                      (wb.v && wb.wr && wb.rd == ex.rs1) ? 2'b10 : 2'b00;
    assign hz.fwd_b = (mem.v && mem.wr && mem.rd == ex.rs2) ? 2'b01 :
                      (wb.v && wb.wr && wb.rd == ex.rs2) ? 2'b10 : 2'b00;
`else
    localparam bit LU_HOLD = 1'b1;
    logic dep_mem, dep_wb;
    assign dep_mem  = mem.v && mem.wr && ((use1 && mem.rd == dec.rs1) || (use2 && mem.rd == dec.rs2));
    assign dep_wb   = wb.v && wb.wr && ((use1 && wb.rd == dec.rs1) || (use2 && wb.rd == dec.rs2));
    assign lu       = hz.id_valid && (dep_ex || dep_mem || dep_wb);
    assign hz.fwd_a = 2'b00;
    assign hz.fwd_b = 2'b00;
`endif

    // Memory wait outranks a taken branch, which squashes any decode-stage stall.
    assign frz   = !hz.mem_ready;
    assign br    = hz.mem_ready && hz.ex_branch_taken;
    assign stall = hz.mem_ready && !hz.ex_branch_taken && lu;

    assign hz.pc_stall     = reset && (frz || stall);
    assign hz.if_id_stall  = reset && (frz || stall);
    assign hz.if_id_flush  = reset && br;
    assign hz.id_ex_bubble = reset && (br || stall);
    assign hz.pipe_freeze  = reset && frz;
    assign hz.stall_cnt    = cnt;

    assign nxt = frz ? MEM_WAIT :
                 (st == MEM_WAIT) ? RUN :
                 (stall && (LU_HOLD || st == RUN)) ? LU_STALL : RUN;

    assign unused_ok = ^{ex.ld, ex.rs1, ex.rs2, mem.ld, mem.rs1, mem.rs2,
                         wb.ld, wb.rs1, wb.rs2, ir[XLEN-1:25]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
            st  <= RUN;
            cnt <= '0;
        end else begin
            st <= nxt;
            if (frz || stall)
                cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (!frz) begin
                ex  <= (br || stall) ? '0 : dec;
                mem <= ex;
                wb  <= mem;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for stall, flush, freeze and forwarding behaviour.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;
    int   exp_cnt;
    logic [31:0] lw5, add6, add3, sub4, addi0, add7;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_op(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [6:0] f7);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_op(logic [6:0] op, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] ir, input logic v, input logic br, input logic mr);
        @(negedge clk);
        hz.id_ir           = ir;
        hz.id_valid        = v;
        hz.ex_branch_taken = br;
        hz.mem_ready       = mr;
        #1;
    endtask

    task automatic drain(input int k);
        repeat (k) cyc(32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Presents ir until decode accepts it; returns the number of stalled cycles.
    task automatic issue(input logic [31:0] ir, output int stalls);
        stalls = 0;
        cyc(ir, 1'b1, 1'b0, 1'b1);
        while (hz.pc_stall && stalls < 10) begin
            stalls++;
            cyc(ir, 1'b1, 1'b0, 1'b1);
        end
    endtask

    initial begin
        lw5   = i_op(7'b0000011, 3'b010, 5'd5, 5'd1, 12'd0);
        add6  = r_op(5'd6, 5'd5, 5'd2, 7'b0000000);
        add3  = r_op(5'd3, 5'd1, 5'd2, 7'b0000000);
        sub4  = r_op(5'd4, 5'd3, 5'd3, 7'b0100000);
        addi0 = i_op(7'b0010011, 3'b000, 5'd0, 5'd0, 12'd1);
        add7  = r_op(5'd7, 5'd0, 5'd0, 7'b0000000);

        reset              = 1'b0;
        hz.id_ir           = add6;
        hz.id_valid        = 1'b1;
        hz.ex_branch_taken = 1'b1;
        hz.mem_ready       = 1'b0;
        #1;
        chk("rst_pc_stall", 32'(hz.pc_stall), 0);
        chk("rst_if_id_stall", 32'(hz.if_id_stall), 0);
        chk("rst_flush", 32'(hz.if_id_flush), 0);
        chk("rst_bubble", 32'(hz.id_ex_bubble), 0);
        chk("rst_freeze", 32'(hz.pipe_freeze), 0);
        chk("rst_fwd", 32'({hz.fwd_a, hz.fwd_b}), 0);
        chk("rst_cnt", hz.stall_cnt, 0);
        @(posedge clk);
        hz.id_valid        = 1'b0;
        hz.ex_branch_taken = 1'b0;
        hz.mem_ready       = 1'b1;
        @(negedge clk);
        reset = 1'b1;

        cyc(lw5, 1'b1, 1'b0, 1'b1);
        chk("a_lw_pc", 32'(hz.pc_stall), 0);
        cyc(add6, 1'b1, 1'b0, 1'b1);
        chk("a_pc", 32'(hz.pc_stall), 1);
        chk("a_if_id", 32'(hz.if_id_stall), 1);
        chk("a_bubble", 32'(hz.id_ex_bubble), 1);
        chk("a_flush", 32'(hz.if_id_flush), 0);
        chk("a_freeze", 32'(hz.pipe_freeze), 0);
        issue(add6, n);
        chk("a_extra_stalls", n, FWD ? 0 : 2);
        cyc(32'd0, 1'b0, 1'b0, 1'b1);
        chk("a_fwd_a", 32'(hz.fwd_a), FWD ? 2 : 0);
        chk("a_fwd_b", 32'(hz.fwd_b), 0);
        exp_cnt = FWD ? 1 : 3;
        chk("a_cnt", hz.stall_cnt, exp_cnt);
        drain(3);

        issue(add3, n);
        chk("b_add3_stalls", n, 0);
        issue(sub4, n);
        chk("b_sub_stalls", n, FWD ? 0 : 3);
        cyc(32'd0, 1'b0, 1'b0, 1'b1);
        chk("b_fwd_a", 32'(hz.fwd_a), FWD ? 1 : 0);
        chk("b_fwd_b", 32'(hz.fwd_b), FWD ? 1 : 0);
        exp_cnt += FWD ? 0 : 3;
        drain(3);

        cyc(lw5, 1'b1, 1'b0, 1'b1);
        cyc(add6, 1'b1, 1'b1, 1'b1);
        chk("c_flush", 32'(hz.if_id_flush), 1);
        chk("c_bubble", 32'(hz.id_ex_bubble), 1);
        chk("c_pc", 32'(hz.pc_stall), 0);
        chk("c_if_id", 32'(hz.if_id_stall), 0);
        cyc(add6, 1'b1, 1'b0, 1'b1);
        chk("c_cnt", hz.stall_cnt, exp_cnt);
        chk("c_after_pc", 32'(hz.pc_stall), FWD ? 0 : 1);
        exp_cnt += FWD ? 0 : 1;
        drain(4);

        issue(add3, n);
        issue(sub4, n);
        chk("d_sub_stalls", n, FWD ? 0 : 3);
        exp_cnt += FWD ? 0 : 3;
        for (int i = 0; i < 3; i++) begin
            cyc(32'd0, 1'b0, i == 0, 1'b0);
            chk("d_freeze", 32'(hz.pipe_freeze), 1);
            chk("d_pc", 32'(hz.pc_stall), 1);
            chk("d_flush", 32'(hz.if_id_flush), 0);
            chk("d_bubble", 32'(hz.id_ex_bubble), 0);
            chk("d_fwd_a_frz", 32'(hz.fwd_a), FWD ? 1 : 0);
        end
        exp_cnt += 3;
        cyc(32'd0, 1'b0, 1'b0, 1'b1);
        chk("d_exit_freeze", 32'(hz.pipe_freeze), 0);
        chk("d_exit_pc", 32'(hz.pc_stall), 0);
        chk("d_exit_fwd_a", 32'(hz.fwd_a), FWD ? 1 : 0);
        chk("d_exit_fwd_b", 32'(hz.fwd_b), FWD ? 1 : 0);
        chk("d_cnt", hz.stall_cnt, exp_cnt);
        drain(4);

        cyc(addi0, 1'b1, 1'b0, 1'b1);
        chk("e_addi_pc", 32'(hz.pc_stall), 0);
        cyc(add7, 1'b1, 1'b0, 1'b1);
        chk("e_add_pc", 32'(hz.pc_stall), 0);
        cyc(32'd0, 1'b0, 1'b0, 1'b1);
        chk("e_fwd", 32'({hz.fwd_a, hz.fwd_b}), 0);
        chk("e_cnt", hz.stall_cnt, exp_cnt);
        drain(3);

        cyc(lw5, 1'b1, 1'b0, 1'b1);
        cyc(add6, 1'b1, 1'b0, 1'b1);
        chk("f_pc", 32'(hz.pc_stall), 1);
        reset = 1'b0;
        #1;
        chk("f_rst_pc", 32'(hz.pc_stall), 0);
        chk("f_rst_if_id", 32'(hz.if_id_stall), 0);
        chk("f_rst_bubble", 32'(hz.id_ex_bubble), 0);
        chk("f_rst_cnt", hz.stall_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(add6, 1'b1, 1'b0, 1'b1);
        chk("f_run_pc", 32'(hz.pc_stall), 0);
        chk("f_run_fwd", 32'({hz.fwd_a, hz.fwd_b}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
